// File: rtl/sum_bcd_display_pkg.sv
// Shared definitions for the sum_bcd_display block.
//   - Active-low 7-segment patterns (seg[6:0] = g,f,e,d,c,b,a) for the
//     digits 0..9, a dash (overflow) and blank (all segments off).
//   - DEC_MAX: the largest value that fits in two decimal digits.
//   - FSM state encoding used by the converter.
package sum_bcd_display_pkg;

  localparam logic [7:0] DEC_MAX = 8'd99;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

endpackage

// File: rtl/sum_bcd_display_bcd_to_7seg.sv
// Combinational BCD nibble to active-low 7-segment decoder.
// Ports:
//   nibble - BCD digit 0..9; 4'hF is the overflow marker (dash),
//            4'hA..4'hE never occur and are shown blank
//   blank  - force all segments off (leading-zero blanking)
//   seg    - active-low pattern, seg[6:0] = g,f,e,d,c,b,a
module bcd_to_7seg
  import sum_bcd_display_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (nibble)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        4'hF:    seg = SEG_DASH;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/sum_bcd_display.sv
// Binary sum (0..255) to two-digit BCD with a multiplexed 7-seg display.
// A load in IDLE starts an 8-cycle shift-add-3 conversion; the result
// (or a dash pair on overflow) is published with a one-cycle done pulse.
// Handshake: load is honoured only in IDLE; busy is high for the 8
// conversion cycles, and done pulses for one cycle with tens/units/ovf
// already holding the new result. Loads seen while busy or during the done
// cycle are dropped, never queued.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   soma, load        - value to convert and its one-cycle request
//   busy, done        - conversion in progress / result-updated pulse
//   ovf, tens, units  - last result; digits are 4'hF when ovf=1
//   seg, an           - active-low segments and digit enables
//                       (an[0] = units, an[1] = tens)
//   state_dbg         - current FSM state
module sum_bcd_display
  import sum_bcd_display_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter bit BLANK_LZ    = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] soma,
  input  logic       load,
  output logic       busy,
  output logic       done,
  output logic       ovf,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic [1:0] state_dbg
);

  localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  state_e        state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [11:0]   bcd_q, bcd_d;
  logic [11:0]   adj;
  logic [2:0]    iter_q, iter_d;
  logic          ovf_pend_q, ovf_pend_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          ovf_q, ovf_d;
  logic [3:0]    tens_q, tens_d;
  logic [3:0]    units_q, units_d;
  logic [RW-1:0] refresh_q, refresh_d;
  logic [1:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          wrap;
  logic          sel_tens;
  logic [3:0]    sel_nibble;
  logic          sel_blank;
  logic [6:0]    sel_pattern;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (load) state_d = ST_CONVERT;
      ST_CONVERT: if (iter_q == 3'd7) state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output logic: registered one stage so busy covers the 8 shift cycles
  // and done lines up with the freshly written digits.
  always_comb begin
    busy_d = (state_q == ST_CONVERT);
    done_d = (state_q == ST_DONE);
  end

  // Double-dabble datapath and result capture
  always_comb begin
    shift_d    = shift_q;
    bcd_d      = bcd_q;
    iter_d     = iter_q;
    ovf_pend_d = ovf_pend_q;
    tens_d     = tens_q;
    units_d    = units_q;
    ovf_d      = ovf_q;
    adj        = bcd_q;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          shift_d    = soma;
          bcd_d      = '0;
          iter_d     = '0;
          ovf_pend_d = (soma > DEC_MAX);
        end
      end
      ST_CONVERT: begin
        // Three nibbles so values up to 255 never overflow the accumulator.
        for (int n = 0; n < 3; n++) begin
          if (adj[n*4 +: 4] >= 4'd5) adj[n*4 +: 4] = adj[n*4 +: 4] + 4'd3;
        end
        {bcd_d, shift_d} = {adj, shift_q} << 1;
        iter_d = iter_q + 3'd1;
      end
      ST_DONE: begin
        ovf_d   = ovf_pend_q;
        tens_d  = ovf_pend_q ? 4'hF : bcd_q[7:4];
        units_d = ovf_pend_q ? 4'hF : bcd_q[3:0];
      end
      default: ;
    endcase
  end

  // Display scan: seg and an advance together on each refresh wrap.
  assign wrap       = (refresh_q == RW'(REFRESH_DIV - 1));
  assign sel_tens   = (an_q == 2'b10);  // units shown now, tens next
  assign sel_nibble = sel_tens ? tens_q : units_q;
  assign sel_blank  = sel_tens && BLANK_LZ && (tens_q == 4'd0) && !ovf_q;

  bcd_to_7seg u_dec (
    .nibble (sel_nibble),
    .blank  (sel_blank),
    .seg    (sel_pattern)
  );

  always_comb begin
    refresh_d = wrap ? '0 : refresh_q + RW'(1);
    an_d      = wrap ? ~an_q : an_q;
    seg_d     = wrap ? sel_pattern : seg_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q    <= '0;
      bcd_q      <= '0;
      iter_q     <= '0;
      ovf_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      tens_q     <= '0;
      units_q    <= '0;
      refresh_q  <= '0;
      an_q       <= 2'b10;
      seg_q      <= SEG_0;
    end else begin
      shift_q    <= shift_d;
      bcd_q      <= bcd_d;
      iter_q     <= iter_d;
      ovf_pend_q <= ovf_pend_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      tens_q     <= tens_d;
      units_q    <= units_d;
      refresh_q  <= refresh_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign ovf       = ovf_q;
  assign tens      = tens_q;
  assign units     = units_q;
  assign seg       = seg_q;
  assign an        = an_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_sum_bcd_display.sv
// Testbench for sum_bcd_display. Two instances share stimulus: one with
// leading-zero blanking off, one with it on; both use REFRESH_DIV=4.
module tb_sum_bcd_display;

  localparam int DIV = 4;
  localparam int W   = 41;  // {done cycle[31:0], ovf, tens[3:0], units[3:0]}

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic       load;
  logic [7:0] soma;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       busy, done, ovf;
  logic [3:0] tens, units;
  logic [6:0] seg;
  logic [1:0] an, state_dbg;

  logic       lz_busy, lz_done, lz_ovf;
  logic [3:0] lz_tens, lz_units;
  logic [6:0] lz_seg;
  logic [1:0] lz_an, lz_state_dbg;

  sum_bcd_display #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b0)) dut (
    .clk(clk), .reset(reset), .soma(soma), .load(load),
    .busy(busy), .done(done), .ovf(ovf), .tens(tens), .units(units),
    .seg(seg), .an(an), .state_dbg(state_dbg)
  );

  sum_bcd_display #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b1)) dut_lz (
    .clk(clk), .reset(reset), .soma(soma), .load(load),
    .busy(lz_busy), .done(lz_done), .ovf(lz_ovf), .tens(lz_tens), .units(lz_units),
    .seg(lz_seg), .an(lz_an), .state_dbg(lz_state_dbg)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;
  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse consumes one expected result.
  always @(negedge clk) begin
    if (!reset && done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done=1 expected no pending conversion (t=%0t)", $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("done_cycle", 32'(cyc), mon_e[40:9]);
        chk("ovf", 32'(ovf), 32'(mon_e[8]));
        chk("tens", 32'(tens), 32'(mon_e[7:4]));
        chk("units", 32'(units), 32'(mon_e[3:0]));
        chk("lz_done", 32'(lz_done), 32'd1);
        chk("lz_tens", 32'(lz_tens), 32'(mon_e[7:4]));
        chk("lz_units", 32'(lz_units), 32'(mon_e[3:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Issues a load at the next negedge; the sampling edge is edge 0, so done
  // is seen at the negedge following edge 9.
  task automatic start(input logic [7:0] v, input logic e_ovf,
                       input logic [3:0] e_t, input logic [3:0] e_u);
    logic [31:0] due;
    @(negedge clk);
    soma = v;
    load = 1'b1;
    due  = 32'(cyc + 10);
    exp_q.push_back({due, e_ovf, e_t, e_u});
    @(negedge clk);
    load = 1'b0;
    soma = 8'd0;
  endtask

  task automatic wait_done(input string name, input bit check_busy);
    int busy_n = 0;
    bit got    = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (done) got = 1'b1;
      else begin
        if (busy) busy_n++;
        @(negedge clk);
      end
    end
    chk({name, "_done_seen"}, 32'(got), 32'd1);
    if (got) chk({name, "_busy_at_done"}, 32'(busy), 32'd0);
    if (check_busy) chk({name, "_busy_cycles"}, 32'(busy_n), 32'd8);
    @(negedge clk);
  endtask

  task automatic convert(input string name, input logic [7:0] v, input logic e_ovf,
                         input logic [3:0] e_t, input logic [3:0] e_u);
    start(v, e_ovf, e_t, e_u);
    wait_done(name, 1'b1);
  endtask

  // Samples both scan slots of both instances after the digits settle.
  task automatic check_display(input string name, input logic [6:0] eu, input logic [6:0] et,
                               input logic [6:0] lu, input logic [6:0] lt);
    logic [6:0] got_u, got_t, got_lu, got_lt;
    bit seen_u = 1'b0, seen_t = 1'b0;
    int bad_an = 0;
    got_u = 7'h00; got_t = 7'h00; got_lu = 7'h00; got_lt = 7'h00;
    repeat (2 * DIV + 1) @(negedge clk);
    for (int i = 0; i < 2 * DIV + 2; i++) begin
      if (an == 2'b10) begin seen_u = 1'b1; got_u = seg; end
      else if (an == 2'b01) begin seen_t = 1'b1; got_t = seg; end
      else bad_an++;
      if (lz_an == 2'b10) got_lu = lz_seg;
      else if (lz_an == 2'b01) got_lt = lz_seg;
      else bad_an++;
      @(negedge clk);
    end
    chk({name, "_an_legal"}, 32'(bad_an), 32'd0);
    chk({name, "_both_slots"}, 32'({seen_u, seen_t}), 32'd3);
    chk({name, "_seg_units"}, 32'(got_u), 32'(eu));
    chk({name, "_seg_tens"}, 32'(got_t), 32'(et));
    chk({name, "_lz_seg_units"}, 32'(got_lu), 32'(lu));
    chk({name, "_lz_seg_tens"}, 32'(got_lt), 32'(lt));
  endtask

  task automatic check_reset_values(input string name);
    chk({name, "_busy"}, 32'(busy), 32'd0);
    chk({name, "_done"}, 32'(done), 32'd0);
    chk({name, "_ovf"}, 32'(ovf), 32'd0);
    chk({name, "_tens"}, 32'(tens), 32'd0);
    chk({name, "_units"}, 32'(units), 32'd0);
    chk({name, "_an"}, 32'(an), 32'h2);
    chk({name, "_seg"}, 32'(seg), 32'h40);
    chk({name, "_state"}, 32'(state_dbg), 32'd0);
    chk({name, "_lz_seg"}, 32'(lz_seg), 32'h40);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int dc0;
    logic [1:0] exp_an;
    reset = 1'b1;
    load  = 1'b0;
    soma  = 8'd0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;

    // Idle scan: an toggles every DIV cycles, both slots show "0".
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      exp_an = (((k / DIV) % 2) == 1) ? 2'b01 : 2'b10;
      chk("idle_an", 32'(an), 32'(exp_an));
      chk("idle_seg", 32'(seg), 32'h40);
      chk("idle_lz_seg", 32'(lz_seg), (exp_an == 2'b01) ? 32'h7F : 32'h40);
      chk("idle_busy", 32'(busy), 32'd0);
    end

    convert("c42", 8'd42, 1'b0, 4'd4, 4'd2);
    check_display("d42", 7'h24, 7'h19, 7'h24, 7'h19);

    convert("c99", 8'd99, 1'b0, 4'd9, 4'd9);
    check_display("d99", 7'h10, 7'h10, 7'h10, 7'h10);

    convert("c0", 8'd0, 1'b0, 4'd0, 4'd0);
    check_display("d0", 7'h40, 7'h40, 7'h40, 7'h7F);

    convert("c100", 8'd100, 1'b1, 4'hF, 4'hF);
    check_display("d100", 7'h3F, 7'h3F, 7'h3F, 7'h3F);

    convert("c255", 8'd255, 1'b1, 4'hF, 4'hF);
    check_display("d255", 7'h3F, 7'h3F, 7'h3F, 7'h3F);

    convert("c7", 8'd7, 1'b0, 4'd0, 4'd7);
    check_display("d7", 7'h78, 7'h40, 7'h78, 7'h7F);

    // A second load while busy is dropped.
    dc0 = done_cnt;
    start(8'd15, 1'b0, 4'd1, 4'd5);
    repeat (2) @(negedge clk);
    soma = 8'd88;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    soma = 8'd0;
    wait_done("c15", 1'b0);
    repeat (15) @(negedge clk);
    chk("c15_done_count", 32'(done_cnt - dc0), 32'd1);
    check_display("d15", 7'h12, 7'h79, 7'h12, 7'h79);

    // Reset mid-conversion aborts it without a done pulse.
    dc0 = done_cnt;
    start(8'd63, 1'b0, 4'd6, 4'd3);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check_reset_values("abort");
    @(negedge clk);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt - dc0), 32'd0);
    chk("abort_tens_held", 32'(tens), 32'd0);

    convert("c63", 8'd63, 1'b0, 4'd6, 4'd3);
    check_display("d63", 7'h30, 7'h02, 7'h30, 7'h02);

    repeat (5) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
